n64_rom_arbiter: RTL and testbench

Sequencer and arbiter between the N64 cartridge bus (PI) and the 32 MB SDRAM controller. It decodes ALE_H/ALE_L address phases and READ_N strobes from the cart bus. It prefetches sequential ROM halfwords into a small FIFO so every READ_N strobe is answered from on-chip storage. It shares the single SDRAM request port with a host loader write port, giving N64 prefetch priority. It sits between the pin-level cart interface in `Main` and the SDRAM controller.

---
 rtl/n64_cart_pkg.sv | 22 ++
 rtl/n64_prefetch_fifo.sv | 53 +++++
 rtl/n64_rom_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_n64_rom_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_cart_pkg.sv
// n64_cart_pkg: shared types and constants for the N64 cart ROM path.
// Used by n64_rom_arbiter and n64_prefetch_fifo.
package n64_cart_pkg;

    localparam int ADDR_W = 24;

    localparam logic [15:0] UNDERRUN_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        B_IDLE,
        B_HI,
        B_BURST
    } bus_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_RD,
        A_RD_WAIT,
        A_WR
    } arb_state_t;

endpackage

// File: rtl/n64_prefetch_fifo.sv
// n64_prefetch_fifo: halfword FIFO with flush; push and pop together
// are legal when full (pop frees the slot) and when empty (pop ignored).
module n64_prefetch_fifo
    import n64_cart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [15:0]   push_data,
    input  logic          pop,
    output logic [15:0]   head,
    output logic [CW-1:0] count
);

    logic [15:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push &&
                     ((count != CW'(FIFO_DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/n64_rom_arbiter.sv
// n64_rom_arbiter: PI cart-bus sequencer, ROM prefetch and SDRAM arbiter.
// Define ROM_BYTESWAP_EN to byte-swap prefetched ROM halfwords.
module n64_rom_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = n64_cart_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       n64_ad_in,
    input  logic              n64_ale_h,
    input  logic              n64_ale_l,
    input  logic              n64_read_n,
    output logic [15:0]       n64_ad_out,
    output logic              n64_ad_oe,
    output logic              sdram_req,
    output logic              sdram_we,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [15:0]       sdram_wdata,
    input  logic              sdram_ack,
    input  logic [15:0]       sdram_rdata,
    input  logic              sdram_rvalid,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_wdata,
    output logic              host_ack,
    output logic              underrun
);

    import n64_cart_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              prev_ale_h;
    logic              prev_ale_l;
    logic              prev_read_n;
    logic              ale_h_fall;
    logic              ale_l_fall;
    logic              read_fall;
    bus_state_t        bus_state;
    bus_state_t        bus_next;
    arb_state_t        arb_state;
    arb_state_t        arb_next;
    logic [15:0]       addr_hi;
    logic [ADDR_W-1:0] ptr;
    logic              drop;
    logic              flush;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pf_eligible;
    logic              burst_read;
    logic [15:0]       push_data;
    logic [15:0]       fifo_head;
    logic [CW-1:0]     fifo_count;

    assign ale_h_fall = prev_ale_h && !n64_ale_h;
    assign ale_l_fall = prev_ale_l && !n64_ale_l;
    assign read_fall  = prev_read_n && !n64_read_n;
    assign flush      = ale_h_fall;
    assign burst_read = read_fall && (bus_state == B_BURST);

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));

    // A fresh ALE_H fall blocks issue so no read targets a stale burst.
    assign pf_eligible = (bus_state == B_BURST) &&
                         !fifo_full && !flush;

    assign push = (arb_state == A_RD_WAIT) && sdram_rvalid &&
                  !drop && !flush;
    assign pop  = burst_read && !fifo_empty;

    assign host_ack = (arb_state == A_WR) && sdram_ack;

`ifdef ROM_BYTESWAP_EN
    assign push_data = {sdram_rdata[7:0], sdram_rdata[15:8]};
`else
    assign push_data = sdram_rdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_ale_h  <= 1'b1;
            prev_ale_l  <= 1'b1;
            prev_read_n <= 1'b1;
        end else begin
            prev_ale_h  <= n64_ale_h;
            prev_ale_l  <= n64_ale_l;
            prev_read_n <= n64_read_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_state <= B_IDLE;
        end else begin
            bus_state <= bus_next;
        end
    end

    always_comb begin
        bus_next = bus_state;
        if (n64_ale_h && n64_ale_l) begin
            bus_next = B_IDLE;
        end else if (ale_h_fall) begin
            bus_next = B_HI;
        end else if (ale_l_fall && (bus_state == B_HI)) begin
            bus_next = B_BURST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hi <= '0;
            ptr     <= '0;
        end else begin
            if (ale_h_fall) begin
                addr_hi <= n64_ad_in;
            end
            if (ale_l_fall && (bus_state == B_HI)) begin
                ptr <= ADDR_W'({addr_hi, n64_ad_in} >> 1);
            end else if ((arb_state == A_RD) && sdram_ack &&
                         !drop && !flush) begin
                ptr <= ptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arb_state <= A_IDLE;
        end else begin
            arb_state <= arb_next;
        end
    end

    always_comb begin
        arb_next = arb_state;
        case (arb_state)
            A_IDLE: begin
                if (pf_eligible) begin
                    arb_next = A_RD;
                end else if (host_req) begin
                    arb_next = A_WR;
                end
            end
            A_RD: begin
                if (sdram_ack) begin
                    arb_next = A_RD_WAIT;
                end
            end
            A_RD_WAIT: begin
                if (sdram_rvalid) begin
                    arb_next = A_IDLE;
                end
            end
            A_WR: begin
                if (sdram_ack) begin
                    arb_next = A_IDLE;
                end
            end
            default: arb_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sdram_req   <= 1'b0;
            sdram_we    <= 1'b0;
            sdram_addr  <= '0;
            sdram_wdata <= '0;
        end else if (arb_state == A_IDLE) begin
            if (pf_eligible) begin
                sdram_req  <= 1'b1;
                sdram_we   <= 1'b0;
                sdram_addr <= ptr;
            end else if (host_req) begin
                sdram_req   <= 1'b1;
                sdram_we    <= 1'b1;
                sdram_addr  <= host_addr;
                sdram_wdata <= host_wdata;
            end
        end else if (sdram_ack) begin
            sdram_req <= 1'b0;
        end
    end

    // A flushed read still completes on the SDRAM side; only its data dies.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop <= 1'b0;
        end else if (flush && ((arb_state == A_RD) ||
                     ((arb_state == A_RD_WAIT) && !sdram_rvalid))) begin
            drop <= 1'b1;
        end else if ((arb_state == A_RD_WAIT) && sdram_rvalid) begin
            drop <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n64_ad_out <= '0;
            n64_ad_oe  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            n64_ad_oe <= (bus_state == B_BURST) && !n64_read_n;
            if (burst_read) begin
                if (fifo_empty) begin
                    n64_ad_out <= UNDERRUN_DATA;
                    underrun   <= 1'b1;
                end else begin
                    n64_ad_out <= fifo_head;
                end
            end
        end
    end

    n64_prefetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_n64_rom_arbiter.sv
// tb_n64_rom_arbiter: directed bench with a simple SDRAM responder
// (3-cycle ack, 4-cycle rvalid, data = low address halfword).
module tb_n64_rom_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] n64_ad_in;
    logic        n64_ale_h;
    logic        n64_ale_l;
    logic        n64_read_n;
    logic [15:0] n64_ad_out;
    logic        n64_ad_oe;
    logic        sdram_req;
    logic        sdram_we;
    logic [23:0] sdram_addr;
    logic [15:0] sdram_wdata;
    logic        sdram_ack;
    logic [15:0] sdram_rdata;
    logic        sdram_rvalid;
    logic        host_req;
    logic [23:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic        underrun;

    int          n_chk;
    int          n_pass;
    int          rd_cnt;
    int          wr_cnt;
    int          rd_at_wr;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic [23:0] rd_addr_q[$];
    logic [23:0] m_addr;
    logic        m_we;

    n64_rom_arbiter #(
        .FIFO_DEPTH (4),
        .ADDR_W     (24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .n64_ad_in    (n64_ad_in),
        .n64_ale_h    (n64_ale_h),
        .n64_ale_l    (n64_ale_l),
        .n64_read_n   (n64_read_n),
        .n64_ad_out   (n64_ad_out),
        .n64_ad_oe    (n64_ad_oe),
        .sdram_req    (sdram_req),
        .sdram_we     (sdram_we),
        .sdram_addr   (sdram_addr),
        .sdram_wdata  (sdram_wdata),
        .sdram_ack    (sdram_ack),
        .sdram_rdata  (sdram_rdata),
        .sdram_rvalid (sdram_rvalid),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .underrun     (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rom_hw(input logic [15:0] a);
`ifdef ROM_BYTESWAP_EN
        return {a[7:0], a[15:8]};
`else
        return a;
`endif
    endfunction

    // SDRAM responder: sees req at negedge, drives #1 after posedge.
    initial begin
        sdram_ack    = 1'b0;
        sdram_rvalid = 1'b0;
        sdram_rdata  = '0;
        forever begin
            @(negedge clk);
            if (sdram_req && !reset) begin
                m_addr = sdram_addr;
                m_we   = sdram_we;
                if (m_we) begin
                    wr_addr  = m_addr;
                    wr_data  = sdram_wdata;
                    rd_at_wr = rd_cnt;
                    wr_cnt++;
                end else begin
                    rd_cnt++;
                    rd_addr_q.push_back(m_addr);
                end
                repeat (2) @(posedge clk);
                #1 sdram_ack = 1'b1;
                @(posedge clk);
                #1 sdram_ack = 1'b0;
                if (!m_we) begin
                    repeat (3) @(posedge clk);
                    #1 sdram_rvalid = 1'b1;
                    sdram_rdata = m_addr[15:0];
                    @(posedge clk);
                    #1 sdram_rvalid = 1'b0;
                end
            end
        end
    end

    task automatic addr_phase(input bit drain,
                              input logic [15:0] hi,
                              input logic [15:0] lo);
        n64_ale_h = 1'b1;
        n64_ale_l = 1'b1;
        @(negedge clk);
        if (drain) repeat (20) @(negedge clk);
        rd_cnt = 0;
        wr_cnt = 0;
        rd_addr_q.delete();
        n64_ad_in = hi;
        n64_ale_h = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n64_ad_in = lo;
        n64_ale_l = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_strobe(output logic [15:0] v);
        n64_read_n = 1'b0;
        @(negedge clk);
        v = n64_ad_out;
        check("ad_oe", {31'd0, n64_ad_oe}, 32'd1);
        n64_read_n = 1'b1;
        repeat (9) @(negedge clk);
    endtask

    task automatic check_first_rd(input logic [23:0] exp);
        check("rdq_nonempty", {31'd0, rd_addr_q.size() > 0}, 32'd1);
        if (rd_addr_q.size() > 0) begin
            check("first_rd_addr", {8'd0, rd_addr_q[0]}, {8'd0, exp});
        end
    endtask

    task automatic burst_reads(input string tag,
                               input logic [15:0] base,
                               input int n);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            read_strobe(v);
            check(tag, {16'd0, v},
                  {16'd0, rom_hw(base + 16'(i))});
        end
    endtask

    task automatic check_reset_vals();
        check("rst_ad_out", {16'd0, n64_ad_out}, 32'd0);
        check("rst_ad_oe", {31'd0, n64_ad_oe}, 32'd0);
        check("rst_req", {31'd0, sdram_req}, 32'd0);
        check("rst_we", {31'd0, sdram_we}, 32'd0);
        check("rst_addr", {8'd0, sdram_addr}, 32'd0);
        check("rst_wdata", {16'd0, sdram_wdata}, 32'd0);
        check("rst_host_ack", {31'd0, host_ack}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        bit          got;
        int          extra;
        n_chk      = 0;
        n_pass     = 0;
        reset      = 1'b1;
        n64_ad_in  = '0;
        n64_ale_h  = 1'b1;
        n64_ale_l  = 1'b1;
        n64_read_n = 1'b1;
        host_req   = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        addr_phase(1'b1, 16'h0000, 16'h0000);
        check("req_1cyc", {31'd0, sdram_req}, 32'd0);
        @(negedge clk);
        check("req_2cyc", {31'd0, sdram_req}, 32'd1);
        check("req_we", {31'd0, sdram_we}, 32'd0);
        repeat (40) @(negedge clk);
        burst_reads("burst0", 16'h0000, 4);
        check("burst0_underrun", {31'd0, underrun}, 32'd0);

        addr_phase(1'b1, 16'h0001, 16'hB420);
        repeat (40) @(negedge clk);
        check_first_rd(24'h00DA10);
        burst_reads("offset", 16'hDA10, 4);

        addr_phase(1'b1, 16'h0000, 16'h0040);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (sdram_req) got = 1;
        end
        check("host_first_req", {31'd0, got}, 32'd1);
        host_addr  = 24'h000100;
        host_wdata = 16'h1234;
        host_req   = 1'b1;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (host_ack) got = 1;
        end
        host_req = 1'b0;
        check("host_ack_seen", {31'd0, got}, 32'd1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_ack) extra++;
        end
        check("host_ack_pulses", 32'(extra), 32'd0);
        check("wr_cnt", 32'(wr_cnt), 32'd1);
        check("wr_addr", {8'd0, wr_addr}, 32'h000100);
        check("wr_data", {16'd0, wr_data}, 32'h1234);
        check("rd_before_wr", 32'(rd_at_wr), 32'd4);
        burst_reads("contend", 16'h0020, 4);

        addr_phase(1'b1, 16'h0000, 16'h0100);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (sdram_ack) got = 1;
        end
        check("flush_ack_seen", {31'd0, got}, 32'd1);
        addr_phase(1'b0, 16'h0000, 16'h0300);
        repeat (40) @(negedge clk);
        check_first_rd(24'h000180);
        burst_reads("flush", 16'h0180, 2);

        addr_phase(1'b1, 16'h0000, 16'h0000);
        n64_read_n = 1'b0;
        @(negedge clk);
        check("under_data", {16'd0, n64_ad_out}, 32'hDEAD);
        check("under_flag", {31'd0, underrun}, 32'd1);
        check("under_oe", {31'd0, n64_ad_oe}, 32'd1);
        n64_read_n = 1'b1;
        repeat (40) @(negedge clk);
        burst_reads("after_under", 16'h0000, 1);
        check("under_sticky", {31'd0, underrun}, 32'd1);
        n64_ale_h = 1'b1;
        n64_ale_l = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_under", {31'd0, underrun}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
